// File: rtl/uart_sender.sv
`default_nettype none
// ============================================================================
// Module   : uart_sender
// Purpose  : UART 8N1 serial transmitter. Accepts one byte on a start pulse,
//            sends start bit, 8 data bits LSB first, and stop bit, holding
//            busy high for the whole frame.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sender #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       out
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int c_CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_baud_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;

  // Single frame sequencer; busy and out are registered so the TX line never glitches.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      busy       <= 1'b0;
      out        <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          busy       <= 1'b0;
          out        <= 1'b1;
          r_baud_cnt <= '0;
          if (start) begin
            // Byte is captured here; later changes on data do not affect the frame.
            r_shift <= data;
            busy    <= 1'b1;
            out     <= 1'b0;
            r_state <= START;
          end
        end

        START: begin
          if (r_baud_cnt == c_CNT_LAST) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            out        <= r_shift[0];
            r_state    <= DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + c_CNT_ONE;
          end
        end

        DATA: begin
          if (r_baud_cnt == c_CNT_LAST) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              out     <= 1'b1;
              r_state <= STOP;
            end else begin
              // Next bit is shift[1] now, which becomes shift[0] after the shift.
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              out       <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + c_CNT_ONE;
          end
        end

        STOP: begin
          if (r_baud_cnt == c_CNT_LAST) begin
            // Returning to IDLE guarantees one idle-high clock before the next frame.
            r_baud_cnt <= '0;
            busy       <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_baud_cnt <= r_baud_cnt + c_CNT_ONE;
          end
        end

        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          out     <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_sender
// Purpose  : Self-checking bench for uart_sender with CLKS_PER_BIT = 4.
//            Reference model predicts line/busy timing from acceptance time;
//            a receiver-style monitor decodes frames and pops a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_sender;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b1;
  logic       start   = 1'b0;
  logic [7:0] data    = 8'h00;
  logic       busy;
  logic       out;

  uart_sender #(.CLK_FREQ(400), .BAUD(100)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .data    (data),
    .busy    (busy),
    .out     (out)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame occupies FRAME edges after acceptance; the next
  // request can only be accepted FRAME+1 edges later.
  logic [7:0] exp_q[$];
  int         cyc       = 0;
  int         next_free = 0;
  int         acc_cyc   = -1000;
  logic [7:0] acc_data  = 8'h00;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      acc_cyc   = -1000;
      next_free = 0;
    end else begin
      cyc++;
      if (start && cyc >= next_free) begin
        acc_cyc   = cyc;
        acc_data  = data;
        next_free = cyc + FRAME + 1;
        exp_q.push_back(data);
      end
    end
  end

  function automatic logic model_busy();
    int j;
    j = cyc - acc_cyc;
    return (j >= 0 && j < FRAME);
  endfunction

  function automatic logic model_out();
    int j;
    int s;
    j = cyc - acc_cyc;
    if (j < 0 || j >= FRAME) return 1'b1;
    s = j / CPB;
    if (s == 0) return 1'b0;
    if (s <= 8) return acc_data[s-1];
    return 1'b1;
  endfunction

  // Cycle-by-cycle comparison of line and busy against the model.
  always @(negedge clock) begin
    check("busy_cycle", {31'd0, busy}, {31'd0, model_busy()});
    check("out_cycle",  {31'd0, out},  {31'd0, model_out()});
  end

  // Receiver-style monitor: decodes each frame at mid-bit and pops the scoreboard.
  logic       rx_active = 1'b0;
  int         rx_cnt    = 0;
  logic [7:0] rx_byte   = 8'h00;
  int         bcnt      = 0;
  logic       bprev     = 1'b0;
  int         rx_s;

  always @(negedge clock) begin
    if (!reset_n) begin
      rx_active = 1'b0;
    end else if (rx_active) begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        rx_s = rx_cnt / CPB;
        if (rx_s == 0) begin
          check("start_bit", {31'd0, out}, 32'd0);
        end else if (rx_s <= 8) begin
          rx_byte[rx_s-1] = out;
        end else begin
          check("stop_bit", {31'd0, out}, 32'd1);
          check("frame_expected", {31'd0, exp_q.size() > 0}, 32'd1);
          if (exp_q.size() > 0) check("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
          rx_active = 1'b0;
        end
      end
    end else if (out == 1'b0) begin
      rx_active = 1'b1;
      rx_cnt    = 0;
    end

    // Busy pulse length per completed frame.
    if (!reset_n) begin
      bcnt  = 0;
      bprev = 1'b0;
    end else if (busy) begin
      bcnt++;
      bprev = 1'b1;
    end else begin
      if (bprev) check("busy_len", bcnt, FRAME);
      bprev = 1'b0;
      bcnt  = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse(input logic [7:0] d);
    @(negedge clock);
    data  = d;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    tick(3);
    @(posedge clock);
    #2 reset_n = 1'b1;

    // Idle after reset.
    tick(20);

    // 0xB2 frame; busy visible on the cycle after acceptance.
    pulse(8'hB2);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    tick(45);

    // Data changes after acceptance must not corrupt the frame.
    pulse(8'h20);
    data = 8'hFF;
    tick(45);

    // Start during a frame is ignored.
    pulse(8'h5A);
    tick(14);
    pulse(8'hC3);
    tick(30);

    // Start held high: back-to-back frames with random data.
    @(negedge clock);
    start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      data = 8'($urandom);
      @(negedge clock);
    end
    start = 1'b0;
    tick(50);

    // Reset during data bit 3, then a clean frame.
    pulse(8'h96);
    tick(16);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("reset_out", {31'd0, out}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    tick(2);
    @(posedge clock);
    #2 reset_n = 1'b1;
    tick(3);
    pulse(8'h3C);
    tick(45);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      start = ($urandom % 6) == 0;
      data  = 8'($urandom);
    end
    @(negedge clock);
    start = 1'b0;
    tick(50);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
